// File: rtl/switch_pkg.sv
// switch_pkg: shared types and helpers for the 4-port switch
package switch_pkg;
  localparam int NUM_PORTS = 4;
  typedef struct packed {
    logic [3:0] target;
    logic [3:0] source;
  } hdr_t;
  typedef enum logic [2:0] {W_IDLE, W_LEN, W_PAYLOAD, W_DROP_LEN, W_DROP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LEN, R_PAY} rd_state_t;
  function automatic logic is_onehot4(input logic [3:0] v);
    return v != 4'd0 && (v & (v - 4'd1)) == 4'd0;
  endfunction
endpackage

// File: rtl/sf_fifo_mem.sv
// sf_fifo_mem: byte-wide register array with one write port and a combinational read port
module sf_fifo_mem #(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  // storage write; contents need no reset because pointers gate every read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/switch_port_ingress.sv
// switch_port_ingress: validates byte-serial packets and forwards good ones store-and-forward to the fabric
module switch_port_ingress
  import switch_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int DEPTH = 64,
  parameter int MAX_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [NUM_PORTS-1:0] out_dest,
  input  logic                 out_ready,
  output logic [7:0]           drop_cnt,
  output logic [7:0]           pkt_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] OCC_MAX = (AW+1)'(DEPTH - MAX_LEN - 2);
  wr_state_t ws, ws_nx;
  rd_state_t rs, rs_nx;
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, occ;
  logic [7:0] remaining, rd_remaining, rd_byte;
  logic [3:0] dest_q;
  logic acc, hdr_ok, len_ok, last, we, commit, rewind, drop_inc, rd_hs;
  hdr_t hdr;
  assign hdr = hdr_t'(in_data);
  assign hdr_ok = is_onehot4(hdr.target) && hdr.source == 4'(1 << PORT_ID) && hdr.target != hdr.source;
  assign len_ok = in_data != 8'd0 && in_data <= 8'(MAX_LEN);
  assign last = remaining == 8'd1;
  assign occ = wr_ptr - rd_ptr;
  sf_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(in_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_byte)
  );
  // state registers for both FSMs
  always_ff @(posedge clk) begin
    if (rst) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
    end else begin
      ws <= ws_nx;
      rs <= rs_nx;
    end
  end
  // write FSM next state, advanced only on accepted bytes
  always_comb begin
    ws_nx = ws;
    if (acc) begin
      case (ws)
        W_IDLE:     ws_nx = hdr_ok ? W_LEN : W_DROP_LEN;
        W_LEN:      ws_nx = len_ok ? W_PAYLOAD : (in_data == 8'd0 ? W_IDLE : W_DROP);
        W_PAYLOAD:  ws_nx = last ? W_IDLE : W_PAYLOAD;
        W_DROP_LEN: ws_nx = in_data == 8'd0 ? W_IDLE : W_DROP;
        W_DROP:     ws_nx = last ? W_IDLE : W_DROP;
        default:    ws_nx = W_IDLE;
      endcase
    end
  end
  // write FSM outputs; a new packet starts only when a maximal packet is guaranteed to fit
  always_comb begin
    in_ready = ws != W_IDLE || occ <= OCC_MAX;
    acc = in_valid && in_ready;
    we = acc && ((ws == W_IDLE && hdr_ok) || (ws == W_LEN && len_ok) || ws == W_PAYLOAD);
    commit = acc && ws == W_PAYLOAD && last;
    rewind = acc && ws == W_LEN && !len_ok;
    drop_inc = rewind || (acc && ws == W_DROP_LEN);
  end
  // read FSM next state, advanced only on output handshakes
  always_comb begin
    rs_nx = rs;
    if (rd_hs) begin
      case (rs)
        R_IDLE:  rs_nx = R_LEN;
        R_LEN:   rs_nx = R_PAY;
        R_PAY:   rs_nx = rd_remaining == 8'd1 ? R_IDLE : R_PAY;
        default: rs_nx = R_IDLE;
      endcase
    end
  end
  // read FSM outputs; data is zeroed while idle so outputs read 0 out of reset
  always_comb begin
    out_valid = commit_ptr != rd_ptr;
    rd_hs = out_valid && out_ready;
    out_data = out_valid ? rd_byte : 8'd0;
    out_sop = out_valid && rs == R_IDLE;
    out_eop = out_valid && rs == R_PAY && rd_remaining == 8'd1;
    out_dest = !out_valid ? 4'd0 : rs == R_IDLE ? rd_byte[7:4] : dest_q;
  end
  // pointers, length counters and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      remaining <= '0;
      rd_remaining <= '0;
      dest_q <= '0;
      drop_cnt <= '0;
      pkt_cnt <= '0;
    end else begin
      wr_ptr <= rewind ? commit_ptr : wr_ptr + (we ? ONE : '0);
      if (commit) commit_ptr <= wr_ptr + ONE;
      if (commit) pkt_cnt <= pkt_cnt + 8'd1;
      if (drop_inc && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (acc && (ws == W_LEN || ws == W_DROP_LEN)) remaining <= in_data;
      else if (acc && (ws == W_PAYLOAD || ws == W_DROP)) remaining <= remaining - 8'd1;
      rd_ptr <= rd_ptr + (rd_hs ? ONE : '0);
      if (rd_hs && rs == R_IDLE) dest_q <= rd_byte[7:4];
      if (rd_hs && rs == R_LEN) rd_remaining <= rd_byte;
      else if (rd_hs && rs == R_PAY) rd_remaining <= rd_remaining - 8'd1;
    end
  end
endmodule
